// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Contents: FSM state encoding, memory command polarity, requester indices,
// and the two-way round-robin pick function used by rr_arb2.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic MEM_READ   = 1'b1;
    localparam logic MEM_WRITE  = 1'b0;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Lone requester wins; with both requesting, the port not granted last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic win;
        case (req)
            2'b01:   win = PORT_FETCH;
            2'b10:   win = PORT_DATA;
            2'b11:   win = ~last;
            default: win = PORT_FETCH;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// slave  : arbiter view (requests and mem_data_in in; grants, rvalid,
//          rdata and the memory command bus out).
// master : environment view (requesters plus memory model), the mirror image.
interface mem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          p0_req;
    logic          p1_req;
    logic          p0_read_write;
    logic          p1_read_write;
    logic [AW-1:0] p0_address;
    logic [AW-1:0] p1_address;
    logic [DW-1:0] p0_wdata;
    logic [DW-1:0] p1_wdata;
    logic          p0_gnt;
    logic          p1_gnt;
    logic          p0_rvalid;
    logic          p1_rvalid;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_address;
    logic          mem_read_write;
    logic          mem_enable;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] mem_data_in;

    modport slave (
        input  p0_req, p1_req, p0_read_write, p1_read_write,
        input  p0_address, p1_address, p0_wdata, p1_wdata, mem_data_in,
        output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata,
        output mem_address, mem_read_write, mem_enable, mem_data_out
    );

    modport master (
        output p0_req, p1_req, p0_read_write, p1_read_write,
        output p0_address, p1_address, p0_wdata, p1_wdata, mem_data_in,
        input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, rdata,
        input  mem_address, mem_read_write, mem_enable, mem_data_out
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector (purely combinational).
// req_i   : request vector, bit 0 = fetch port, bit 1 = data port
// last_i  : index of the port granted most recently
// win_o   : index of the selected port
// valid_o : at least one request present
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       valid_o
);

    // Winner selection and request-present flag.
    always_comb begin
        win_o   = rr_pick(req_i, last_i);
        valid_o = |req_i;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter (fetch port 0, data port 1).
// clk   : single clock, rising edge
// reset : asynchronous, active-low
// bus   : mem_arbiter_if slave modport carrying both requester channels,
//         the shared rdata return and the memory command bus.
// Flow per transaction: IDLE (sample + latch winner) -> ISSUE (command on
// the bus, winner's gnt) -> RESP for reads (rvalid) -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    state_e        state_q,    state_d;
    logic [1:0]    gnt_q,      gnt_d;
    logic [1:0]    rvalid_q,   rvalid_d;
    logic          last_q,     last_d;
    logic          mem_en_q,   mem_en_d;
    logic          mem_rw_q,   mem_rw_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_dout_q, mem_dout_d;
    logic [DW-1:0] rdata_q,    rdata_d;

    logic [1:0]    req_s;
    logic          win_s;
    logic          valid_s;
    logic          sel_rw_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    assign req_s = {bus.p1_req, bus.p0_req};

    rr_arb2 u_rr_arb2 (
        .req_i   (req_s),
        .last_i  (last_q),
        .win_o   (win_s),
        .valid_o (valid_s)
    );

    // Mux the winning requester's command fields.
    always_comb begin
        if (win_s == PORT_DATA) begin
            sel_rw_s    = bus.p1_read_write;
            sel_addr_s  = bus.p1_address;
            sel_wdata_s = bus.p1_wdata;
        end else begin
            sel_rw_s    = bus.p0_read_write;
            sel_addr_s  = bus.p0_address;
            sel_wdata_s = bus.p0_wdata;
        end
    end

    // Next-state and next-output logic. The command and gnt are loaded on
    // the IDLE sampling edge so they appear registered during ISSUE.
    always_comb begin
        state_d    = state_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        last_d     = last_q;
        mem_en_d   = 1'b0;
        mem_rw_d   = MEM_READ;
        mem_addr_d = mem_addr_q;
        mem_dout_d = {DW{1'b0}};
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (valid_s) begin
                    state_d        = ISSUE;
                    last_d         = win_s;
                    gnt_d[win_s]   = 1'b1;
                    mem_en_d       = 1'b1;
                    mem_rw_d       = sel_rw_s;
                    mem_addr_d     = sel_addr_s;
                    mem_dout_d     = (sel_rw_s == MEM_READ) ? {DW{1'b0}} : sel_wdata_s;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // mem_rw_q still holds the command being issued this cycle.
                if (mem_rw_q == MEM_READ) begin
                    state_d          = RESP;
                    rvalid_d[last_q] = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = bus.mem_data_in;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset prefers port 0 by marking port 1 as last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            last_q     <= PORT_DATA;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= MEM_READ;
            mem_addr_q <= {AW{1'b0}};
            mem_dout_q <= {DW{1'b0}};
            rdata_q    <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            last_q     <= last_d;
            mem_en_q   <= mem_en_d;
            mem_rw_q   <= mem_rw_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.p0_gnt         = gnt_q[PORT_FETCH];
    assign bus.p1_gnt         = gnt_q[PORT_DATA];
    assign bus.p0_rvalid      = rvalid_q[PORT_FETCH];
    assign bus.p1_rvalid      = rvalid_q[PORT_DATA];
    assign bus.mem_enable     = mem_en_q;
    assign bus.mem_read_write = mem_rw_q;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_data_out   = mem_dout_q;

    // Memory data arrives during RESP, the same cycle rvalid must be shown,
    // so rdata bypasses the capture register then and holds it otherwise.
    assign bus.rdata = (state_q == RESP) ? bus.mem_data_in : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset values, a directed vector
// table, hand-written multi-cycle sequences and a randomized run checked
// against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bif ();
    mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bif));

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_env [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    typedef struct {
        logic        port;
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    // Memory model: command sampled on the rising edge, read data valid the next cycle.
    always @(posedge clk) begin
        if (bif.mem_enable) begin
            if (bif.mem_read_write) begin
                bif.mem_data_in <= mem_env.exists(bif.mem_address) ? mem_env[bif.mem_address] : 16'h0000;
            end else begin
                mem_env[bif.mem_address] = bif.mem_data_out;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] gnt_v();
        return {bif.p1_gnt, bif.p0_gnt};
    endfunction

    function automatic logic [1:0] rv_v();
        return {bif.p1_rvalid, bif.p0_rvalid};
    endfunction

    task automatic drive_port(input logic port, input logic req, input logic rw,
                              input logic [15:0] addr, input logic [15:0] wd);
        if (port) begin
            bif.p1_req = req; bif.p1_read_write = rw; bif.p1_address = addr; bif.p1_wdata = wd;
        end else begin
            bif.p0_req = req; bif.p0_read_write = rw; bif.p0_address = addr; bif.p0_wdata = wd;
        end
    endtask

    task automatic idle_inputs();
        drive_port(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        drive_port(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " gnt"},   {30'd0, gnt_v()}, 32'd0);
        chk({tag, " rvalid"},{30'd0, rv_v()},  32'd0);
        chk({tag, " en"},    {31'd0, bif.mem_enable},     32'd0);
        chk({tag, " rw"},    {31'd0, bif.mem_read_write}, 32'd1);
        chk({tag, " addr"},  {16'd0, bif.mem_address},    32'd0);
        chk({tag, " dout"},  {16'd0, bif.mem_data_out},   32'd0);
        chk({tag, " rdata"}, {16'd0, bif.rdata},          32'd0);
    endtask

    // Asynchronous assert mid-cycle, release on a falling edge.
    task automatic apply_reset();
        idle_inputs();
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One isolated transaction with exact latency checks; starts and ends in IDLE at a negedge.
    task automatic run_txn(input vec_t v, input int i);
        logic [1:0] pbit;
        pbit = v.port ? 2'b10 : 2'b01;
        drive_port(v.port, 1'b1, v.rw, v.addr, v.wdata);
        @(negedge clk);
        chk($sformatf("vec%0d gnt", i),   {30'd0, gnt_v()}, {30'd0, pbit});
        chk($sformatf("vec%0d en", i),    {31'd0, bif.mem_enable}, 32'd1);
        chk($sformatf("vec%0d rw", i),    {31'd0, bif.mem_read_write}, {31'd0, v.rw});
        chk($sformatf("vec%0d addr", i),  {16'd0, bif.mem_address}, {16'd0, v.addr});
        chk($sformatf("vec%0d dout", i),  {16'd0, bif.mem_data_out}, v.rw ? 32'd0 : {16'd0, v.wdata});
        chk($sformatf("vec%0d rv@1", i),  {30'd0, rv_v()}, 32'd0);
        drive_port(v.port, 1'b0, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        chk($sformatf("vec%0d gnt@2", i), {30'd0, gnt_v()}, 32'd0);
        if (v.rw) begin
            chk($sformatf("vec%0d rv", i),    {30'd0, rv_v()}, {30'd0, pbit});
            chk($sformatf("vec%0d rdata", i), {16'd0, bif.rdata}, {16'd0, v.exp_rdata});
            @(negedge clk);
            chk($sformatf("vec%0d rdata hold", i), {16'd0, bif.rdata}, {16'd0, v.exp_rdata});
        end else begin
            chk($sformatf("vec%0d rv", i), {30'd0, rv_v()}, 32'd0);
        end
        chk($sformatf("vec%0d en idle", i),   {31'd0, bif.mem_enable}, 32'd0);
        chk($sformatf("vec%0d rw idle", i),   {31'd0, bif.mem_read_write}, 32'd1);
        chk($sformatf("vec%0d addr hold", i), {16'd0, bif.mem_address}, {16'd0, v.addr});
    endtask

    // Randomized-phase state: requester agents and reference model.
    logic        a_req  [2];
    logic        a_rw   [2];
    logic [15:0] a_addr [2];
    logic [15:0] a_wd   [2];

    int          m_busy;
    logic        m_last;
    logic [1:0]  m_gnt, m_rv, m_nxt_rv;
    logic [15:0] m_nxt_rd, m_rdata, m_addr, m_wd;
    logic        m_rw;

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'h0010;
            2:       return 16'hFFFF;
            default: return 16'($urandom_range(0, 65535));
        endcase
    endfunction

    // Arbiter behaviour at transaction level: sample when free, grant,
    // then stay deaf for one edge after a write or two after a read.
    task automatic model_edge();
        logic w;
        m_rv = m_nxt_rv;
        if (m_rv != 2'b00) m_rdata = m_nxt_rd;
        m_nxt_rv = 2'b00;
        m_gnt = 2'b00;
        if (m_busy > 0) begin
            m_busy--;
        end else if (a_req[0] || a_req[1]) begin
            if (a_req[0] && a_req[1]) w = (m_last == 1'b0) ? 1'b1 : 1'b0;
            else                      w = a_req[1] ? 1'b1 : 1'b0;
            m_last = w;
            m_gnt[w] = 1'b1;
            m_rw   = a_rw[w];
            m_addr = a_addr[w];
            m_wd   = a_wd[w];
            if (m_rw) begin
                m_nxt_rv[w] = 1'b1;
                m_nxt_rd = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 16'h0000;
                m_busy = 2;
            end else begin
                ref_mem[m_addr] = m_wd;
                m_busy = 1;
            end
        end
    endtask

    vec_t vecs [8];

    initial begin
        logic [1:0] g;
        logic [1:0] pat;

        vecs[0] = '{1'b1, 1'b0, 16'h0000, 16'h5A5A, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 16'h5A5A};
        vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 16'h1234, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h1234};
        vecs[4] = '{1'b1, 1'b0, 16'h0010, 16'hC3C3, 16'h0000};
        vecs[5] = '{1'b0, 1'b1, 16'h0010, 16'h0000, 16'hC3C3};
        vecs[6] = '{1'b1, 1'b0, 16'h7FFF, 16'h8001, 16'h0000};
        vecs[7] = '{1'b1, 1'b1, 16'h7FFF, 16'h0000, 16'h8001};

        bif.mem_data_in = 16'h0000;
        idle_inputs();
        #2 reset = 1'b0;
        #1 chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        // Directed table.
        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Both ports hold reads from reset release: p0, p1, p0, p1 every 3 cycles.
        reset = 1'b0;
        drive_port(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
        drive_port(1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            pat = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
            chk($sformatf("rr c%0d gnt", c), {30'd0, gnt_v()}, (c % 3 == 0) ? {30'd0, pat} : 32'd0);
            chk($sformatf("rr c%0d rv", c),  {30'd0, rv_v()},  (c % 3 == 1) ? {30'd0, pat} : 32'd0);
            if (c % 3 == 1)
                chk($sformatf("rr c%0d rdata", c), {16'd0, bif.rdata},
                    (pat == 2'b01) ? 32'h0000_C3C3 : 32'h0000_5A5A);
        end

        // Write request arriving during a read's RESP is held off, then granted.
        apply_reset();
        drive_port(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("hold p0 gnt", {30'd0, gnt_v()}, 32'd1);
        drive_port(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);
        chk("hold p0 rv", {30'd0, rv_v()}, 32'd1);
        chk("hold p0 rdata", {16'd0, bif.rdata}, 32'h0000_5A5A);
        drive_port(1'b1, 1'b1, 1'b0, 16'h0010, 16'hA5A5);
        @(negedge clk);
        chk("hold gap gnt", {30'd0, gnt_v()}, 32'd0);
        chk("hold gap rv",  {30'd0, rv_v()},  32'd0);
        @(negedge clk);
        chk("hold p1 gnt",  {30'd0, gnt_v()}, 32'd2);
        chk("hold p1 rv",   {30'd0, rv_v()},  32'd0);
        chk("hold p1 addr", {16'd0, bif.mem_address},  32'h0000_0010);
        chk("hold p1 dout", {16'd0, bif.mem_data_out}, 32'h0000_A5A5);
        chk("hold p1 rw",   {31'd0, bif.mem_read_write}, 32'd0);
        drive_port(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        @(negedge clk);

        // Reset during RESP aborts the read.
        apply_reset();
        drive_port(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000);
        @(negedge clk);
        chk("abort gnt", {30'd0, gnt_v()}, 32'd1);
        drive_port(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_vals("abort");
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("abort c%0d rv", c),  {30'd0, rv_v()},  32'd0);
            chk($sformatf("abort c%0d gnt", c), {30'd0, gnt_v()}, 32'd0);
        end

        // Idle run: nothing moves.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle c%0d en", c),  {31'd0, bif.mem_enable}, 32'd0);
            chk($sformatf("idle c%0d gnt", c), {30'd0, gnt_v()}, 32'd0);
            chk($sformatf("idle c%0d rv", c),  {30'd0, rv_v()},  32'd0);
        end

        // Randomized traffic against the reference model.
        apply_reset();
        mem_env.delete();
        ref_mem.delete();
        for (int p = 0; p < 2; p++) begin
            a_req[p] = 1'b0; a_rw[p] = 1'b1; a_addr[p] = 16'h0000; a_wd[p] = 16'h0000;
        end
        m_busy = 0; m_last = 1'b1; m_nxt_rv = 2'b00; m_rv = 2'b00; m_gnt = 2'b00;
        m_rdata = 16'h0000; m_addr = 16'h0000; m_wd = 16'h0000; m_rw = 1'b1; m_nxt_rd = 16'h0000;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            chk($sformatf("rnd c%0d gnt", c),   {30'd0, gnt_v()}, {30'd0, m_gnt});
            chk($sformatf("rnd c%0d rv", c),    {30'd0, rv_v()},  {30'd0, m_rv});
            chk($sformatf("rnd c%0d rdata", c), {16'd0, bif.rdata}, {16'd0, m_rdata});
            chk($sformatf("rnd c%0d en", c),    {31'd0, bif.mem_enable}, {31'd0, (m_gnt != 2'b00)});
            chk($sformatf("rnd c%0d addr", c),  {16'd0, bif.mem_address}, {16'd0, m_addr});
            chk($sformatf("rnd c%0d rw", c),    {31'd0, bif.mem_read_write},
                (m_gnt != 2'b00) ? {31'd0, m_rw} : 32'd1);
            chk($sformatf("rnd c%0d dout", c),  {16'd0, bif.mem_data_out},
                ((m_gnt != 2'b00) && !m_rw) ? {16'd0, m_wd} : 32'd0);
            chk($sformatf("rnd c%0d onehot", c), $countones({gnt_v(), rv_v()}) <= 1 ? 32'd1 : 32'd0, 32'd1);
            g = gnt_v();
            for (int p = 0; p < 2; p++) begin
                if (a_req[p] && g[p]) a_req[p] = 1'b0;
                if (!a_req[p] && ($urandom_range(0, 2) != 0)) begin
                    a_req[p]  = 1'b1;
                    a_rw[p]   = 1'($urandom_range(0, 1));
                    a_addr[p] = pick_addr();
                    a_wd[p]   = 16'($urandom_range(0, 65535));
                end
                drive_port(p[0], a_req[p], a_rw[p], a_addr[p], a_wd[p]);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
